// File: rtl/hold_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : hold_arbiter_if
// Description : Request/grant bundle between level requesters and the
//               hold arbiter. The master side drives requests; the slave
//               side (the arbiter) returns the registered grant outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hold_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             busy;

    // Requester side
    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hold_arbiter
// Description : Round-robin arbiter for one held output channel. A grant is
//               held for at least MIN_HOLD cycles, released when the owner
//               drops its request, and force-released after MAX_HOLD cycles
//               when another requester is waiting. Every release is followed
//               by GAP cooldown cycles before the next arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16,
    parameter int GAP      = 1,
    parameter int CNT_W    = 26
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    hold_arbiter_if.slave   bus
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [CNT_W-1:0] C_MIN_LAST = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] C_MAX_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [N_REQ-1:0] C_ONE      = N_REQ'(1);
    localparam logic [ID_W-1:0]  C_LAST_RST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             busy_q, busy_d;

    logic             sel_found_w;
    logic [ID_W-1:0]  sel_idx_w;
    logic             owner_req_w;
    logic             others_req_w;
    logic             release_w;

    // Round-robin search: first set request after the last owner, wrapping,
    // with the last owner itself examined last so a sole requester re-wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        sel_found_w = 1'b0;
        sel_idx_w   = '0;
        idx         = 0;
        cand        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx  = (int'(last_q) + i) % N_REQ;
            cand = ID_W'(idx);
            if (!sel_found_w && bus.req[cand]) begin
                sel_found_w = 1'b1;
                sel_idx_w   = cand;
            end
        end
    end

    // Release decision for the current owner (gnt_q is its one-hot vector).
    always_comb begin
        owner_req_w  = bus.req[gnt_id_q];
        others_req_w = |(bus.req & ~gnt_q);
        release_w    = ((cnt_q >= C_MIN_LAST) && !owner_req_w) ||
                       ((cnt_q >= C_MAX_LAST) && others_req_w);
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                busy_d      = 1'b0;
                cnt_d       = '0;
                if (sel_found_w) begin
                    state_d     = ST_GRANT;
                    gnt_d       = C_ONE << sel_idx_w;
                    gnt_id_d    = sel_idx_w;
                    gnt_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_GRANT: begin
                busy_d = 1'b1;
                if (release_w) begin
                    state_d     = ST_COOLDOWN;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_id_q;
                    cnt_d       = '0;
                end else if (cnt_q < C_MAX_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_COOLDOWN: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                busy_d      = 1'b1;
                if (cnt_q == C_GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                busy_d      = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers; reset takes effect without a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= C_LAST_RST;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hold_arbiter
// Description : Directed self-checking bench for hold_arbiter with the
//               default parameters (4 requesters, hold 4..16, gap 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hold_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hold_arbiter_if #(.N_REQ(4)) bus ();

    hold_arbiter #(
        .N_REQ    (4),
        .MIN_HOLD (4),
        .MAX_HOLD (16),
        .GAP      (1),
        .CNT_W    (26)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a grant to exp_id for len cycles, then the two low cycles
    // (COOLDOWN then IDLE evaluation). Starts on the first grant cycle.
    task automatic run_grant(input int exp_id, input int len);
        logic [3:0] oh;
        oh = 4'b0001 << exp_id;
        for (int i = 0; i < len; i++) begin
            check("gnt",       32'(bus.gnt),       32'(oh));
            check("gnt_id",    32'(bus.gnt_id),    32'(exp_id));
            check("gnt_valid", 32'(bus.gnt_valid), 32'd1);
            tick();
        end
        check("gap0_gnt",  32'(bus.gnt),    32'd0);
        check("gap0_busy", 32'(bus.busy),   32'd1);
        check("gap0_id",   32'(bus.gnt_id), 32'(exp_id));
        tick();
        check("gap1_gnt",  32'(bus.gnt),       32'd0);
        check("gap1_vld",  32'(bus.gnt_valid), 32'd0);
        check("gap1_busy", 32'(bus.busy),      32'd0);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        bus.req  = '0;
        #3 rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_gnt",   32'(bus.gnt),       32'd0);
        check("rst_id",    32'(bus.gnt_id),    32'd0);
        check("rst_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);

        // Release reset with only requester 3: pointer starts at 3, 3 still wins
        bus.req = 4'b1000;
        rst_n   = 1'b1;
        tick();
        check("rel_gnt",  32'(bus.gnt),    32'h8);
        check("rel_id",   32'(bus.gnt_id), 32'd3);
        check("rel_busy", 32'(bus.busy),   32'd1);
        bus.req = '0;
        for (int i = 0; i < 6; i++) tick();
        check("rel_idle", 32'(bus.busy), 32'd0);

        // Short pulse on requester 2: stretched to exactly 4 cycles
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        for (int i = 0; i < 4; i++) begin
            check("short_gnt",  32'(bus.gnt),  32'h4);
            check("short_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        check("short_cool_gnt",  32'(bus.gnt),  32'd0);
        check("short_cool_busy", 32'(bus.busy), 32'd1);
        tick();
        check("short_idle_busy", 32'(bus.busy),   32'd0);
        check("short_idle_id",   32'(bus.gnt_id), 32'd2);
        tick();

        // Long owner, no contention: 10 cycles of request -> 10 cycles of grant
        bus.req = 4'b0010;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("long_gnt", 32'(bus.gnt), 32'h2);
            if (i == 9) bus.req = '0;
            tick();
        end
        check("long_end_gnt", 32'(bus.gnt), 32'd0);
        tick();
        tick();

        // Reset in the middle of a grant to requester 2 (c=5)
        bus.req = 4'b0100;
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("mid_gnt_pre", 32'(bus.gnt), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_gnt",   32'(bus.gnt),       32'd0);
        check("mid_valid", 32'(bus.gnt_valid), 32'd0);
        check("mid_busy",  32'(bus.busy),      32'd0);
        bus.req = 4'b1100;
        tick();
        rst_n = 1'b1;
        tick();
        run_grant(2, 16);
        run_grant(3, 16);
        run_grant(2, 16);

        // Forced release between requesters 0 and 3
        rst_n   = 1'b0;
        bus.req = 4'b1001;
        tick();
        rst_n = 1'b1;
        tick();
        run_grant(0, 16);
        run_grant(3, 16);
        run_grant(0, 16);

        // Fairness with all four requesting
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();
        run_grant(0, 16);
        run_grant(1, 16);
        run_grant(2, 16);
        run_grant(3, 16);
        run_grant(0, 16);
        run_grant(1, 16);

        bus.req = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/hold_arbiter.md
Name: hold_arbiter

Overview:
- Round-robin arbiter that shares one held output channel (e.g. a stretched key/action command) among N_REQ level requesters.
- Each grant is held for a minimum time, released when the owner drops its request, and force-released at a maximum time if another requester is waiting.
- Sits between the per-input pulse holders and the game-logic consumer, so only one action is active at a time.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MIN_HOLD, 4, minimum grant length in cycles (>=1).
- MAX_HOLD, 16, grant length after which the grant is forced off if another request is pending (>=MIN_HOLD).
- GAP, 1, idle cycles in COOLDOWN after each release (>=1).
- CNT_W, 26, hold/gap counter width; MAX_HOLD and GAP must each be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- req  in  N_REQ  level requests, one bit per requester.
- gnt  out  N_REQ  one-hot grant, registered.
- gnt_id  out  max(1,clog2(N_REQ))  index of the current or last owner, registered.
- gnt_valid  out  1  high when gnt is nonzero, registered.
- busy  out  1  high when the state is not IDLE, registered.

Behaviour:
- Reset (rst=0, async): gnt=0, gnt_id=0, gnt_valid=0, busy=0, state=IDLE, counter=0, last=N_REQ-1, so requester 0 has top priority first. Outputs clear immediately, without waiting for clk.
- States: IDLE, GRANT, COOLDOWN.
- IDLE:
  - If req != 0, select the first set bit searching from (last+1) mod N_REQ upward with wrap.
  - At the next edge: gnt=onehot(sel), gnt_id=sel, gnt_valid=1, busy=1, counter=0, state=GRANT. Latency from req to gnt is 1 cycle.
  - If req == 0, remain in IDLE with outputs 0 (gnt_id keeps its last value).
- GRANT (owner o, counter c; c=0 in the first grant cycle):
  - Release if (c >= MIN_HOLD-1 and req[o]==0) or (c >= MAX_HOLD-1 and (req & ~onehot(o)) != 0).
  - On release, at the next edge: gnt=0, gnt_valid=0, last=o, counter=0, state=COOLDOWN. The grant is therefore high for exactly c+1 cycles.
  - Otherwise counter = c+1, saturating at MAX_HOLD-1.
  - The owner keeps the grant indefinitely while it holds req and no other requester is waiting.
  - If the owner drops req before MIN_HOLD, the grant is still stretched to exactly MIN_HOLD cycles.
  - Re-assertion of req[o] during the grant has no effect beyond keeping the release condition false.
- COOLDOWN:
  - gnt=0, busy=1. Counter increments each cycle.
  - When counter == GAP-1, the next edge moves to IDLE with busy=0 and counter=0.
  - Requests are level-sensitive and never latched, so one dropped during COOLDOWN is not served.
- Gap between grants: minimum of GAP+1 low cycles on gnt (COOLDOWN plus one IDLE evaluation cycle).
- Simultaneous requests: resolved only by the round-robin pointer. After owner o, requester o+1 wins over o-1.
- Wrap-around: the pointer wraps from N_REQ-1 to 0. The search covers all N_REQ bits, including o itself last, so a sole requester is re-granted after the gap.
- Invariants: gnt is one-hot or zero; gnt_valid == |gnt; gnt never changes owner without passing through COOLDOWN.

Test Plan (defaults N_REQ=4, MIN_HOLD=4, MAX_HOLD=16, GAP=1):
- Reset: hold rst=0 mid-simulation with req=4'b1111 -> gnt=0, gnt_valid=0, busy=0 within the same cycle. Release rst with req=4'b1000 -> gnt=4'b1000, gnt_id=3 one cycle later.
- Short pulse: req[2] high for 1 cycle at cycle k -> gnt=4'b0100, gnt_id=2 high for cycles k+1..k+4 (exactly 4), COOLDOWN at k+5, IDLE at k+6, busy low from k+6.
- Long owner, no contention: req[1] high for cycles k..k+9 -> gnt=4'b0010 for cycles k+1..k+10 (10 cycles), low at k+11.
- Forced release: req[0] and req[3] both held continuously from reset -> gnt0 for 16 cycles, 2 low cycles, gnt3 for 16 cycles, 2 low cycles, gnt0 again, repeating.
- Fairness: req=4'b1111 held -> grant order 0,1,2,3,0,1. Each grant lasts 16 cycles; gnt is never multi-hot.
- Reset mid-grant: during a req[2] grant at c=5, pulse rst=0 -> gnt=0 immediately. After release, with req=4'b1100 -> grant goes to 2 first (pointer reset to 3), then to 3.
